// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the write master and the slave stage on the same bus.
// Holds the transaction state encoding, R/W bit values and the quarter-phase width.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK1,
    DATA,
    ACK2,
    STOP
  } i2c_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam int QPH_W = 2;
  typedef logic [QPH_W-1:0] qphase_t;

  function automatic logic is_ack_state(input i2c_state_t s);
    return (s == ACK1) || (s == ACK2);
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period timebase: counts 0..CLK_DIV-1 and flags the last count as a tick.
// Restart realigns the count so the first quarter after a command is a full one.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign tick = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/i2c_master_wr.sv
// Single-byte I2C write master: START, address+W, ACK, data, ACK, STOP.
// Bus pins are registered on the tick that closes each quarter, so pins trail the FSM by one quarter.
module i2c_master_wr
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       i2c_scl,
  inout  wire        i2c_sda
);

  i2c_state_t state_reg, state_next;
  qphase_t    phase_reg, phase_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] addr_sr_reg, data_sr_reg;
  logic       scl_reg, scl_next;
  logic       sda_low_reg, sda_low_next;
  logic       ready_reg, busy_reg, done_reg, nack_reg;
  logic       addr_shift, data_shift, nack_set, finish;
  logic       tick, accept, cur_msb;

  assign accept  = cmd_valid && ready_reg;
  assign cur_msb = (state_reg == DATA) ? data_sr_reg[7] : addr_sr_reg[7];

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .tick    (tick)
  );

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg + 2'd1;
    bit_cnt_next = bit_cnt_reg;
    scl_next     = scl_reg;
    sda_low_next = sda_low_reg;
    addr_shift   = 1'b0;
    data_shift   = 1'b0;
    nack_set     = 1'b0;
    finish       = 1'b0;
    case (state_reg)
      START: begin
        scl_next     = 1'b1;
        sda_low_next = 1'b1;
        if (phase_reg == 2'd1) begin
          state_next   = ADDR;
          phase_next   = '0;
          bit_cnt_next = 3'd7;
        end
      end
      ADDR, ACK1, DATA, ACK2: begin
        case (phase_reg)
          2'd0: begin
            scl_next     = 1'b0;
            sda_low_next = is_ack_state(state_reg) ? 1'b0 : !cur_msb;
          end
          2'd1:    scl_next = 1'b0;
          default: scl_next = 1'b1;
        endcase
        // Pins are still showing q2 here, so this is the last clk of SCL's first high half.
        if (phase_reg == 2'd3) begin
          case (state_reg)
            ADDR: begin
              addr_shift = 1'b1;
              if (bit_cnt_reg == 3'd0) state_next = ACK1;
              else bit_cnt_next = bit_cnt_reg - 3'd1;
            end
            DATA: begin
              data_shift = 1'b1;
              if (bit_cnt_reg == 3'd0) state_next = ACK2;
              else bit_cnt_next = bit_cnt_reg - 3'd1;
            end
            ACK1: begin
              bit_cnt_next = 3'd7;
              nack_set     = i2c_sda;
              state_next   = i2c_sda ? STOP : DATA;
            end
            default: begin
              nack_set   = i2c_sda;
              state_next = STOP;
            end
          endcase
        end
      end
      STOP: begin
        case (phase_reg)
          2'd0: begin
            scl_next     = 1'b0;
            sda_low_next = 1'b1;
          end
          2'd1: begin
            scl_next     = 1'b1;
            sda_low_next = 1'b1;
          end
          default: begin
            scl_next     = 1'b1;
            sda_low_next = 1'b0;
            state_next   = IDLE;
            phase_next   = '0;
            finish       = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      phase_reg   <= '0;
      bit_cnt_reg <= 3'd7;
      addr_sr_reg <= '0;
      data_sr_reg <= '0;
      scl_reg     <= 1'b1;
      sda_low_reg <= 1'b0;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      nack_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        addr_sr_reg <= {cmd_addr, I2C_RW_WRITE};
        data_sr_reg <= cmd_data;
        state_reg   <= START;
        phase_reg   <= '0;
        bit_cnt_reg <= 3'd7;
        ready_reg   <= 1'b0;
        busy_reg    <= 1'b1;
        nack_reg    <= 1'b0;
      end else if (tick && busy_reg) begin
        state_reg   <= state_next;
        phase_reg   <= phase_next;
        bit_cnt_reg <= bit_cnt_next;
        scl_reg     <= scl_next;
        sda_low_reg <= sda_low_next;
        if (addr_shift) addr_sr_reg <= {addr_sr_reg[6:0], 1'b0};
        if (data_shift) data_sr_reg <= {data_sr_reg[6:0], 1'b0};
        if (nack_set) nack_reg <= 1'b1;
        if (finish) begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready = ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign nack      = nack_reg;
  assign i2c_scl   = scl_reg;
  assign i2c_sda   = sda_low_reg ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: slave model ACKs by counting SCL falls, monitor records SDA at SCL rises.
// Expected bit streams and latencies come from the protocol rules, not from the design's FSM.
module tb_i2c_master_wr;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, busy, done, nack, i2c_scl;
  wire        i2c_sda;
  logic       slave_low = 1'b0;

  pullup (i2c_sda);
  assign i2c_sda = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_wr #(.CLK_DIV(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .busy      (busy),
    .done      (done),
    .nack      (nack),
    .i2c_scl   (i2c_scl),
    .i2c_sda   (i2c_sda)
  );

  int   total = 0;
  int   bad = 0;
  int   starts = 0, stops = 0, falls = 0, done_count = 0, done_wide = 0;
  bit   ack_addr = 1'b1, ack_data = 1'b1;
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_done = 1'b0;
  logic rise_q[$];
  logic exp_q[$];

  // Bus monitor and slave model, sampled half a clock away from the DUT's edge.
  always @(negedge clk) begin
    logic sda_now;
    sda_now = i2c_sda;
    if (prev_scl && i2c_scl && (sda_now !== prev_sda)) begin
      if (!sda_now) starts++;
      else stops++;
    end
    if (!prev_scl && i2c_scl) rise_q.push_back(sda_now);
    if (prev_scl && !i2c_scl) begin
      falls++;
      slave_low = (falls == 9 && ack_addr) || (falls == 18 && ack_data);
    end
    if (done) done_count++;
    if (done && prev_done) done_wide++;
    prev_scl  = i2c_scl;
    prev_sda  = sda_now;
    prev_done = done;
  end

  function automatic logic [31:0] pack_q(input logic q[$]);
    logic [31:0] v;
    v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  // Reference: bits seen on SCL rises are addr+W, ack slot, [data, ack slot], then STOP's SCL rise with SDA low.
  task automatic build_exp(input logic [6:0] a, input logic [7:0] d, input bit aa, input bit ad);
    logic [7:0] ab;
    ab = {a, 1'b0};
    exp_q.delete();
    for (int i = 7; i >= 0; i--) exp_q.push_back(ab[i]);
    exp_q.push_back(!aa);
    if (aa) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
      exp_q.push_back(!ad);
    end
    exp_q.push_back(1'b0);
  endtask

  task automatic clear_monitor();
    falls = 0;
    starts = 0;
    stops = 0;
    slave_low = 1'b0;
    rise_q.delete();
  endtask

  task automatic do_txn(input logic [6:0] a, input logic [7:0] d, input bit aa, input bit ad,
                        output int lat, output int first_fall, output logic nack_at_done);
    int n;
    ack_addr = aa;
    ack_data = ad;
    clear_monitor();
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_addr  = 7'($urandom);
    cmd_data  = 8'($urandom);
    lat = -1;
    first_fall = -1;
    nack_at_done = 1'bx;
    for (n = 1; n <= 100 * C; n++) begin
      @(posedge clk); #1;
      if (first_fall < 0 && i2c_sda === 1'b0) first_fall = n;
      if (done) begin
        lat = n;
        nack_at_done = nack;
        break;
      end
    end
    @(negedge clk); #1;
    $display("txn addr=%h data=%h ack_a=%0d ack_d=%0d latency=%0d nack=%b", a, d, aa, ad, lat, nack_at_done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (nack !== 1'b0) begin bad++; $display("FAIL reset_nack got=%b want=0", nack); end
    total++; if (i2c_scl !== 1'b1) begin bad++; $display("FAIL reset_scl got=%b want=1", i2c_scl); end
    total++; if (i2c_sda !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b want=released", i2c_sda); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    logic [6:0] a;
    logic [7:0] d;
    int lat, ff;
    logic nk;
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 7'h08 : 7'($urandom);
      d = (k == 0) ? 8'hA5 : 8'($urandom);
      build_exp(a, d, 1'b1, 1'b1);
      do_txn(a, d, 1'b1, 1'b1, lat, ff, nk);
      total++; if (lat !== 77 * C) begin bad++; $display("FAIL write_latency addr=%h got=%0d want=%0d", a, lat, 77 * C); end
      total++; if (nk !== 1'b0) begin bad++; $display("FAIL write_nack addr=%h got=%b want=0", a, nk); end
      total++; if (rise_q.size() != exp_q.size() || pack_q(rise_q) !== pack_q(exp_q)) begin
        bad++; $display("FAIL write_bits got=%0d:%b want=%0d:%b", rise_q.size(), pack_q(rise_q), exp_q.size(), pack_q(exp_q));
      end
      total++; if (starts != 1 || stops != 1) begin bad++; $display("FAIL write_bus_edges got start=%0d stop=%0d want 1/1", starts, stops); end
      total++; if (ff != C) begin bad++; $display("FAIL write_start_delay got=%0d want=%0d", ff, C); end
    end
  endtask

  task automatic test_addr_nack();
    logic [6:0] a;
    logic [7:0] d;
    int lat, ff;
    logic nk;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 7'h15 : 7'($urandom);
      d = 8'($urandom);
      build_exp(a, d, 1'b0, 1'b1);
      do_txn(a, d, 1'b0, 1'b1, lat, ff, nk);
      total++; if (lat !== 41 * C) begin bad++; $display("FAIL anack_latency got=%0d want=%0d", lat, 41 * C); end
      total++; if (nk !== 1'b1) begin bad++; $display("FAIL anack_nack got=%b want=1", nk); end
      total++; if (rise_q.size() != exp_q.size() || pack_q(rise_q) !== pack_q(exp_q)) begin
        bad++; $display("FAIL anack_bits got=%0d:%b want=%0d:%b", rise_q.size(), pack_q(rise_q), exp_q.size(), pack_q(exp_q));
      end
      total++; if (starts != 1 || stops != 1) begin bad++; $display("FAIL anack_bus_edges got start=%0d stop=%0d want 1/1", starts, stops); end
    end
  endtask

  task automatic test_data_nack();
    int lat, ff;
    logic nk;
    build_exp(7'h2C, 8'hFF, 1'b1, 1'b0);
    do_txn(7'h2C, 8'hFF, 1'b1, 1'b0, lat, ff, nk);
    total++; if (lat !== 77 * C) begin bad++; $display("FAIL dnack_latency got=%0d want=%0d", lat, 77 * C); end
    total++; if (nk !== 1'b1) begin bad++; $display("FAIL dnack_nack got=%b want=1", nk); end
    total++; if (rise_q.size() != exp_q.size() || pack_q(rise_q) !== pack_q(exp_q)) begin
      bad++; $display("FAIL dnack_bits got=%0d:%b want=%0d:%b", rise_q.size(), pack_q(rise_q), exp_q.size(), pack_q(exp_q));
    end
    total++; if (starts != 1 || stops != 1) begin bad++; $display("FAIL dnack_bus_edges got start=%0d stop=%0d want 1/1", starts, stops); end
  endtask

  task automatic test_random();
    logic [6:0] a;
    logic [7:0] d;
    bit aa, ad;
    int lat, ff;
    logic nk;
    for (int k = 0; k < 6; k++) begin
      a  = 7'($urandom);
      d  = 8'($urandom);
      aa = 1'($urandom_range(0, 1));
      ad = 1'($urandom_range(0, 1));
      build_exp(a, d, aa, ad);
      do_txn(a, d, aa, ad, lat, ff, nk);
      total++; if (lat !== (aa ? 77 : 41) * C) begin bad++; $display("FAIL rand_latency got=%0d want=%0d", lat, (aa ? 77 : 41) * C); end
      total++; if (nk !== (!aa || !ad)) begin bad++; $display("FAIL rand_nack got=%b want=%b", nk, (!aa || !ad)); end
      total++; if (rise_q.size() != exp_q.size() || pack_q(rise_q) !== pack_q(exp_q)) begin
        bad++; $display("FAIL rand_bits got=%0d:%b want=%0d:%b", rise_q.size(), pack_q(rise_q), exp_q.size(), pack_q(exp_q));
      end
      total++; if (starts != 1 || stops != 1) begin bad++; $display("FAIL rand_bus_edges got start=%0d stop=%0d want 1/1", starts, stops); end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] a;
    logic [7:0] d1, d2;
    int n, t1, t2, dones0;
    a = 7'($urandom);
    d1 = 8'($urandom);
    ack_addr = 1'b1;
    ack_data = 1'b1;
    clear_monitor();
    dones0 = done_count;
    cmd_addr  = a;
    cmd_data  = d1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    t1 = -1;
    for (n = 1; n <= 100 * C; n++) begin
      cmd_data = 8'($urandom);
      @(posedge clk); #1;
      if (done) begin t1 = n; break; end
    end
    build_exp(a, d1, 1'b1, 1'b1);
    $display("txn b2b first data=%h latency=%0d", d1, t1);
    total++; if (t1 != 77 * C) begin bad++; $display("FAIL b2b_latency1 got=%0d want=%0d", t1, 77 * C); end
    total++; if (rise_q.size() != exp_q.size() || pack_q(rise_q) !== pack_q(exp_q)) begin
      bad++; $display("FAIL b2b_bits1 got=%0d:%b want=%0d:%b", rise_q.size(), pack_q(rise_q), exp_q.size(), pack_q(exp_q));
    end
    d2 = cmd_data;
    falls = 0;
    rise_q.delete();
    @(posedge clk); #1;
    total++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_reaccept got ready=%b busy=%b want ready=0 busy=1", cmd_ready, busy);
    end
    t2 = -1;
    for (n = 1; n <= 100 * C; n++) begin
      cmd_data = 8'($urandom);
      @(posedge clk); #1;
      if (done) begin t2 = n; break; end
    end
    cmd_valid = 1'b0;
    build_exp(a, d2, 1'b1, 1'b1);
    $display("txn b2b second data=%h latency=%0d", d2, t2);
    total++; if (t2 != 77 * C) begin bad++; $display("FAIL b2b_latency2 got=%0d want=%0d", t2, 77 * C); end
    total++; if (rise_q.size() != exp_q.size() || pack_q(rise_q) !== pack_q(exp_q)) begin
      bad++; $display("FAIL b2b_bits2 got=%0d:%b want=%0d:%b", rise_q.size(), pack_q(rise_q), exp_q.size(), pack_q(exp_q));
    end
    repeat (3) @(posedge clk);
    #1;
    total++; if (done_count - dones0 != 2 || done_wide != 0) begin
      bad++; $display("FAIL b2b_done_count got=%0d wide=%0d want=2 wide=0", done_count - dones0, done_wide);
    end
    total++; if (starts != 2 || stops != 2) begin bad++; $display("FAIL b2b_bus_edges got start=%0d stop=%0d want 2/2", starts, stops); end
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got ready=%b busy=%b want 1/0", cmd_ready, busy); end
  endtask

  task automatic test_reset_mid();
    int dones0;
    ack_addr = 1'b1;
    ack_data = 1'b1;
    clear_monitor();
    dones0 = done_count;
    cmd_addr  = 7'($urandom);
    cmd_data  = 8'($urandom);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // Data bit 3 occupies bus quarters 54..57, i.e. edges 55C..59C after accept.
    repeat (56 * C) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1 || falls != 14) begin bad++; $display("FAIL rmid_position got busy=%b slot=%0d want busy=1 slot=14", busy, falls); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("txn reset mid data bit 3");
    total++; if (i2c_scl !== 1'b1) begin bad++; $display("FAIL rmid_scl got=%b want=1", i2c_scl); end
    total++; if (i2c_sda !== 1'b1) begin bad++; $display("FAIL rmid_sda got=%b want=released", i2c_sda); end
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rmid_ready got ready=%b busy=%b want 1/0", cmd_ready, busy); end
    total++; if (done !== 1'b0 || nack !== 1'b0) begin bad++; $display("FAIL rmid_flags got done=%b nack=%b want 0/0", done, nack); end
    repeat (20 * C) @(posedge clk);
    #1;
    total++; if (done_count != dones0 || i2c_scl !== 1'b1) begin
      bad++; $display("FAIL rmid_no_done got dones=%0d scl=%b want dones=%0d scl=1", done_count, i2c_scl, dones0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_nack();
    test_data_nack();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_wr.md
# i2c_master_wr

Single-byte I2C write master sitting directly upstream of the I2C slave stage on the shared bus. Accepts one 7-bit target address plus one data byte from the SPI front end over a valid/ready handshake. Generates START, address with R/W=0, samples the address ACK, sends the data byte, samples the data ACK, then generates STOP. Reports completion and NACK status back to the SPI side.

## Interface
Parameters:
- `CLK_DIV`, default 25: clk cycles per SCL quarter-period. Legal values are ≥2. SCL period is 4*CLK_DIV clk cycles.

Ports:
- `clk`, input, 1: single system clock; all logic on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `cmd_valid`, input, 1: SPI side presents a command.
- `cmd_ready`, output, 1: master idle and able to accept. Reset value 1.
- `cmd_addr`, input, 7: target address, sent MSB first.
- `cmd_data`, input, 8: data byte, sent MSB first.
- `busy`, output, 1: transaction in progress. Reset value 0.
- `done`, output, 1: one-cycle pulse at transaction end. Reset value 0.
- `nack`, output, 1: result of the last transaction; 1 if any ACK slot read high. Valid from `done` until the next accept. Reset value 0.
- `i2c_scl`, output, 1: push-pull SCL; no clock stretching is supported. Reset value 1.
- `i2c_sda`, inout, 1: open-drain. The block drives 0 or releases (z) and never drives 1. Released at reset.

## Operation
- **Accept:** when `cmd_valid && cmd_ready` in IDLE, latch `{cmd_addr, 1'b0}` into an 8-bit shift register and `cmd_data` into a second one. On the same edge, drop `cmd_ready`, raise `busy`, clear `nack`, and restart the quarter counter. `cmd_*` are don't-care while `cmd_ready`=0.
- **Quarter tick:** a counter runs 0..CLK_DIV-1. A tick occurs when it reaches CLK_DIV-1. Every state/phase advance happens only on a tick, and all bus outputs are registered.
- **States:** IDLE → START → ADDR → ACK1 → DATA → ACK2 → STOP → IDLE.
  - If ACK1 is sampled high: set `nack`, skip DATA and ACK2, and go to STOP.
  - A high sample in ACK2 sets `nack`.
- **START** (2 quarters): q0 SCL=1, SDA=0; q1 SCL=1, SDA=0.
- **Bit slot** (ADDR, DATA: 8 slots each; ACK1, ACK2: 1 slot each), 4 quarters per slot:
  - q0: SCL=0; SDA set to the shift-register MSB (0 → drive low, 1 → release). In ACK slots SDA is released.
  - q1: SCL=0.
  - q2: SCL=1. At the end-of-q2 tick, sample `i2c_sda` (ACK slots only).
  - q3: SCL=1.
  - Shift left at the end of q3. A 3-bit bit counter counts 7..0; the state exits after bit 0.
- **STOP** (3 quarters): q0 SCL=0, SDA=0; q1 SCL=1, SDA=0; q2 SCL=1, SDA released.
- **Completion:** on the tick ending STOP q2, enter IDLE. On the same edge, `done`=1 for one cycle, `busy`=0, and `cmd_ready`=1.
- **Bus rules:** SDA changes only while SCL=0, except the START and STOP edges.
- **Backpressure:** `cmd_valid` is ignored while busy. A new command may be accepted on the cycle after `done`, or later.
- **Reset mid-transaction:** on the reset edge, return to IDLE with SCL=1, SDA released, `done`=0, `nack`=0, and `cmd_ready`=1. The truncated bus cycle is not completed.

## Timing
- Accept to first SDA fall (START): CLK_DIV cycles. All outputs are registered; there is no combinational path from `cmd_*` to outputs.
- Full transaction (both ACKs low): 2+36+36+3 = 77 quarters. `done` appears 77*CLK_DIV cycles after the accept edge.
- Address NACK: 2+36+3 = 41 quarters, so `done` appears 41*CLK_DIV cycles after accept.
- ACK sample point: the last clk of the SCL-high first half (end of q2).
- Back-to-back: minimum gap between STOP SDA rise and the next START SDA fall is CLK_DIV+1 cycles.

## Structure
- Shared package `i2c_pkg`:
  - state enum: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP
  - `I2C_RW_WRITE`=1'b0, `I2C_RW_READ`=1'b1
  - quarter-phase width constant (2 bits)
  The slave stage uses the same package.
- Sub-module `i2c_quarter_tick`:
  - parameter `CLK_DIV`
  - inputs `clk`, `rst_n`, `restart`
  - output `tick`
  The FSM, shift registers, and SDA/SCL output registers live in the top module.

## Test plan
1. CLK_DIV=4. Send addr 7'h08, data 8'hA5; the bench slave model ACKs both. Required: SDA bits on SCL rising edges are 0001000_0, then 10100101. `done` at cycle 308 after accept; `nack`=0.
2. Addr 7'h15; the model never ACKs. Required: no data bits are clocked. STOP follows ACK1. `done` at 41*4=164 cycles; `nack`=1.
3. Address ACKed, data NACKed, data 8'hFF. Required: 77*4 cycles to `done`; `nack`=1. SDA stays released through all 8 data bits.
4. Hold `cmd_valid`=1 with changing `cmd_data` during busy. Required: only the first command is sent. The second command is accepted on the cycle after `done`, with exactly one `done` per command.
5. Assert `rst_n`=0 for one cycle mid-DATA bit 3. Required: the next edge shows SCL=1, SDA=z, `cmd_ready`=1, `busy`=0, and no `done` pulse.
6. Bus-protocol monitor over tests 1–4. Required: SDA never changes while SCL=1, except exactly one START fall and one STOP rise per transaction. The block never drives SDA to 1.
